pll_dyn_reconfig: RTL and testbench
===================================

// Module: pll_dyn_reconfig
// PURPOSE
//  Sequencer for run-time divider changes on NUM_PLL Gowin rPLLs with DYN_FBDIV/IDIV/ODIV_SEL="true".
//  Accepts a valid/ready request per channel, holds that PLL in reset and swaps its FBDSEL/IDSEL/ODSEL.
//  Then releases reset and qualifies LOCK, retrying on timeout.
//  Sits between the system control logic and the rPLL instances; drives their RESET and divider buses.
// PARAMETERS
//  NUM_PLL       2       number of PLL channels (1..8)
//  DIV_W         6       divider select width (FBDSEL/IDSEL/ODSEL)
//  INIT_FDIV     6'd0    FBDSEL value on reset, all channels
//  INIT_IDIV     6'd0    IDSEL value on reset, all channels
//  INIT_ODIV     6'd0    ODSEL value on reset, all channels
//  RST_CYCLES    16      clk cycles pll_reset held high per attempt (>=2)
//  SETTLE_CYCLES 64      consecutive synced-lock cycles required to declare lock (>=1)
//  LOCK_TIMEOUT  65536   clk cycles from reset release to give up on an attempt
//  MAX_RETRY     3       extra attempts after first timeout before failing
// PORTS
//  clk        in   1               system clock, single domain
//  reset      in   1               asynchronous, active-high
//  req_valid  in   1               reconfig request
//  req_ready  out  1               high only in IDLE
//  req_sel    in   SW=max(1,clog2(NUM_PLL))  target channel
//  req_fdiv   in   DIV_W           new FBDSEL
//  req_idiv   in   DIV_W           new IDSEL
//  req_odiv   in   DIV_W           new ODSEL
//  pll_lock   in   NUM_PLL         raw rPLL LOCK, asynchronous to clk
//  pll_reset  out  NUM_PLL         to rPLL RESET
//  fdiv_o     out  NUM_PLL*DIV_W   per-channel FBDSEL; channel n at [n*DIV_W +: DIV_W]
//  idiv_o     out  NUM_PLL*DIV_W   per-channel IDSEL
//  odiv_o     out  NUM_PLL*DIV_W   per-channel ODSEL
//  busy       out  1               sequence in progress
//  done       out  1               one-cycle pulse at end of sequence
//  done_ok    out  1               valid with done: 1 = locked, 0 = failed
//  lock_lost  out  NUM_PLL         sticky: synced lock fell while channel not under reconfig
// BEHAVIOUR
//  Reset values:
//   - pll_reset=0, fdiv_o/idiv_o/odiv_o = INIT_* replicated
//   - busy=0, done=0, done_ok=0, lock_lost=0
//   - state IDLE, req_ready=1
//  pll_lock passes through a 2-FF synchroniser per channel. "lock" below means the synced value.
//  FSM states:
//   - IDLE: handshake when req_valid & req_ready. Captures sel/fdiv/idiv/odiv and sets retry=0. Next is RST_ASSERT.
//     req_sel >= NUM_PLL: request is accepted and ignored. done with done_ok=0 pulses the next cycle.
//   - RST_ASSERT: pll_reset[sel]=1 from the first cycle. The divider outputs of sel update in that same first cycle.
//     Held for RST_CYCLES cycles, then RELEASE.
//   - RELEASE: pll_reset[sel]=0. Timeout and settle counters are cleared. Next is WAIT_LOCK.
//   - WAIT_LOCK: each cycle, lock=1 increments settle and lock=0 clears it.
//     settle==SETTLE_CYCLES gives DONE_OK.
//     Timeout counter reaching LOCK_TIMEOUT gives RST_ASSERT if retry<MAX_RETRY (retry++), else DONE_FAIL.
//     Settle wins over timeout in the same cycle.
//   - DONE_OK / DONE_FAIL: single cycle. done=1, done_ok = (state==DONE_OK). Clears lock_lost[sel] on OK. Next is IDLE.
//  busy=1 in every state except IDLE. req_valid while busy is not accepted and has no effect.
//  Divider buses of non-selected channels never change. pll_reset of non-selected channels stays 0.
//  lock_lost[n] is set on a synced 1->0 edge of lock[n] when channel n is not currently under reconfig.
//   It stays set until a DONE_OK for n or reset.
//  Request latency: accept -> pll_reset high is 1 cycle.
//   Minimum request to done = RST_CYCLES + 1 + SETTLE_CYCLES + 1 cycles, lock already high, excluding sync delay.
//  Assertion of reset mid-sequence: everything returns to its reset value immediately.
//   This includes the divider buses reverting to INIT_*.
//  Counters are sized to clog2(max value + 1). They saturate and never wrap.
// STRUCTURE
//  Shared package pll_reconfig_pkg:
//   - FSM state encoding (IDLE, RST_ASSERT, RELEASE, WAIT_LOCK, DONE_OK, DONE_FAIL)
//   - DIV_W default
//   - helper function for counter widths
//  Sub-module pll_lock_sync: NUM_PLL-wide 2-FF synchroniser with async reset to 0.
//  The rest (FSM, counters, divider register file) lives in this module.
// TESTING
//  1. NUM_PLL=2. Request sel=1, fdiv=6'd5, idiv=6'd1, odiv=6'd8. Model lock rises 40 cycles after reset release.
//     -> pll_reset[1] high exactly 16 cycles, fdiv_o[11:6]=5, done&done_ok once, ch0 buses/reset untouched.
//  2. Lock never rises, LOCK_TIMEOUT=200, MAX_RETRY=3.
//     -> four pll_reset[sel] pulses, then done=1 with done_ok=0.
//  3. Lock glitches low for 1 cycle at settle=50.
//     -> settle restarts; done_ok comes 64 cycles after the glitch clears.
//  4. req_valid held during busy with different sel -> no second handshake until IDLE.
//     The second request is then accepted and serviced.
//  5. Drop lock[0] while idle -> lock_lost[0]=1 and sticky. Successful reconfig of ch0 -> lock_lost[0]=0.
//  6. Assert reset during WAIT_LOCK -> all outputs return to reset values within the same cycle (async).
//     req_ready=1 after release.

Source files
------------

// File: rtl/pll_reconfig_pkg.sv
// Shared types and helpers for the rPLL dynamic-reconfiguration sequencer.
package pll_reconfig_pkg;

    localparam int DIV_W_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_ASSERT,
        ST_RELEASE,
        ST_WAIT_LOCK,
        ST_DONE_OK,
        ST_DONE_FAIL
    } state_e;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the asynchronous rPLL LOCK outputs.
module pll_lock_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/pll_dyn_reconfig.sv
// Sequences run-time FBDSEL/IDSEL/ODSEL changes on a bank of rPLLs:
// hold the channel in reset, swap dividers, release, qualify LOCK, retry on timeout.
module pll_dyn_reconfig
    import pll_reconfig_pkg::*;
#(
    parameter int               NUM_PLL       = 2,
    parameter int               DIV_W         = DIV_W_DEF,
    parameter logic [DIV_W-1:0] INIT_FDIV     = '0,
    parameter logic [DIV_W-1:0] INIT_IDIV     = '0,
    parameter logic [DIV_W-1:0] INIT_ODIV     = '0,
    parameter int               RST_CYCLES    = 16,
    parameter int               SETTLE_CYCLES = 64,
    parameter int               LOCK_TIMEOUT  = 65536,
    parameter int               MAX_RETRY     = 3,
    localparam int              SW            = sel_w(NUM_PLL)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [SW-1:0]            req_sel,
    input  logic [DIV_W-1:0]         req_fdiv,
    input  logic [DIV_W-1:0]         req_idiv,
    input  logic [DIV_W-1:0]         req_odiv,
    input  logic [NUM_PLL-1:0]       pll_lock,
    output logic [NUM_PLL-1:0]       pll_reset,
    output logic [NUM_PLL*DIV_W-1:0] fdiv_o,
    output logic [NUM_PLL*DIV_W-1:0] idiv_o,
    output logic [NUM_PLL*DIV_W-1:0] odiv_o,
    output logic                     busy,
    output logic                     done,
    output logic                     done_ok,
    output logic [NUM_PLL-1:0]       lock_lost
);

    localparam int RW = cnt_w(RST_CYCLES);
    localparam int EW = cnt_w(SETTLE_CYCLES);
    localparam int TW = cnt_w(LOCK_TIMEOUT);
    localparam int YW = cnt_w(MAX_RETRY);

    localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);
    localparam logic [EW-1:0] SETTLE_MAX = EW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT);
    localparam logic [YW-1:0] RETRY_MAX  = YW'(MAX_RETRY);

    state_e state, state_nx;

    logic [RW-1:0] rst_cnt;
    logic [EW-1:0] settle;
    logic [TW-1:0] tmo;
    logic [YW-1:0] retry;

    logic [SW-1:0] sel_q;
    logic          sel_ok_q;
    logic [NUM_PLL-1:0] lock_s, lock_d;
    logic [NUM_PLL-1:0][DIV_W-1:0] fdiv_r, idiv_r, odiv_r;

    logic          hs, req_sel_ok, lock_sel;
    logic [SW-1:0] sel_nx;

    pll_lock_sync #(.WIDTH(NUM_PLL)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .din   (pll_lock),
        .dout  (lock_s)
    );

    assign hs         = req_valid && (state == ST_IDLE);
    assign req_sel_ok = int'(req_sel) < NUM_PLL;
    assign lock_sel   = sel_ok_q ? lock_s[sel_q] : 1'b0;
    assign sel_nx     = (state == ST_IDLE) ? req_sel : sel_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:       if (req_valid) state_nx = req_sel_ok ? ST_RST_ASSERT : ST_DONE_FAIL;
            ST_RST_ASSERT: if (rst_cnt == RST_LAST) state_nx = ST_RELEASE;
            ST_RELEASE:    state_nx = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                // A completed settle window beats a simultaneous timeout.
                if (settle == SETTLE_MAX)  state_nx = ST_DONE_OK;
                else if (tmo == TMO_MAX)   state_nx = (retry < RETRY_MAX) ? ST_RST_ASSERT : ST_DONE_FAIL;
            end
            ST_DONE_OK, ST_DONE_FAIL: state_nx = ST_IDLE;
            default:       state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE_OK) || (state == ST_DONE_FAIL);
        done_ok   = (state == ST_DONE_OK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cnt  <= '0;
            settle   <= '0;
            tmo      <= '0;
            retry    <= '0;
            sel_q    <= '0;
            sel_ok_q <= 1'b0;
        end else begin
            if (state != ST_RST_ASSERT)   rst_cnt <= '0;
            else if (rst_cnt != RST_LAST) rst_cnt <= rst_cnt + RW'(1);

            // Cleared outside WAIT_LOCK, which covers the RELEASE cycle.
            if (state != ST_WAIT_LOCK) begin
                settle <= '0;
                tmo    <= '0;
            end else begin
                if (!lock_sel)                settle <= '0;
                else if (settle != SETTLE_MAX) settle <= settle + EW'(1);
                if (tmo != TMO_MAX)           tmo <= tmo + TW'(1);
            end

            if (hs) begin
                retry    <= '0;
                sel_q    <= req_sel;
                sel_ok_q <= req_sel_ok;
            end else if (state == ST_WAIT_LOCK && state_nx == ST_RST_ASSERT) begin
                retry <= retry + YW'(1);
            end
        end
    end

    // Per-channel divider file, reset drive and lock-loss flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NUM_PLL; n++) begin
                fdiv_r[n] <= INIT_FDIV;
                idiv_r[n] <= INIT_IDIV;
                odiv_r[n] <= INIT_ODIV;
            end
            pll_reset <= '0;
            lock_d    <= '0;
            lock_lost <= '0;
        end else begin
            lock_d <= lock_s;
            for (int n = 0; n < NUM_PLL; n++) begin
                if (hs && int'(req_sel) == n) begin
                    fdiv_r[n] <= req_fdiv;
                    idiv_r[n] <= req_idiv;
                    odiv_r[n] <= req_odiv;
                end
                // Registered from next state so RESET is glitch-free and rises one cycle after accept.
                pll_reset[n] <= (state_nx == ST_RST_ASSERT) && (int'(sel_nx) == n);
                if (state == ST_DONE_OK && int'(sel_q) == n)
                    lock_lost[n] <= 1'b0;
                else if (lock_d[n] && !lock_s[n] &&
                         !((state != ST_IDLE) && sel_ok_q && int'(sel_q) == n))
                    lock_lost[n] <= 1'b1;
            end
        end
    end

    for (genvar n = 0; n < NUM_PLL; n++) begin : g_bus
        assign fdiv_o[n*DIV_W +: DIV_W] = fdiv_r[n];
        assign idiv_o[n*DIV_W +: DIV_W] = idiv_r[n];
        assign odiv_o[n*DIV_W +: DIV_W] = odiv_r[n];
    end

endmodule

// File: tb/tb_pll_dyn_reconfig.sv
// Directed bench for pll_dyn_reconfig with a small behavioural rPLL lock model.
module tb_pll_dyn_reconfig;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [0:0] req_sel = '0;
    logic [5:0] req_fdiv = '0, req_idiv = '0, req_odiv = '0;
    logic [1:0] pll_lock, pll_reset, lock_lost;
    logic [11:0] fdiv_o, idiv_o, odiv_o;
    logic       busy, done, done_ok;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_dyn_reconfig #(
        .NUM_PLL(2), .DIV_W(6), .INIT_FDIV(6'd0), .INIT_IDIV(6'd0), .INIT_ODIV(6'd0),
        .RST_CYCLES(16), .SETTLE_CYCLES(64), .LOCK_TIMEOUT(200), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_fdiv(req_fdiv), .req_idiv(req_idiv), .req_odiv(req_odiv),
        .pll_lock(pll_lock), .pll_reset(pll_reset),
        .fdiv_o(fdiv_o), .idiv_o(idiv_o), .odiv_o(odiv_o),
        .busy(busy), .done(done), .done_ok(done_ok), .lock_lost(lock_lost)
    );

    // rPLL model: lock drops while RESET is high, rises lock_delay cycles after release (-1 = never).
    int         lock_delay [2] = '{3, 3};
    logic [1:0] ign_rst = '0, force_low = '0, mlock = '0;
    int         mcnt [2] = '{0, 0};

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (pll_reset[n] && !ign_rst[n]) begin
                mcnt[n]  <= 0;
                mlock[n] <= 1'b0;
            end else if (lock_delay[n] >= 0 && mcnt[n] >= lock_delay[n]) begin
                mlock[n] <= 1'b1;
            end else begin
                mcnt[n] <= mcnt[n] + 1;
            end
        end
    end
    assign pll_lock = mlock & ~force_low;

    // Monitors: reset pulse count/length per channel, done pulses, handshakes.
    int run [2] = '{0, 0};
    int pulses [2] = '{0, 0};
    int badlen [2] = '{0, 0};
    int done_cnt = 0, done_ok_cnt = 0, hs_cnt = 0;

    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (pll_reset[n]) run[n] <= run[n] + 1;
            else if (run[n] != 0) begin
                pulses[n] <= pulses[n] + 1;
                if (run[n] != 16) badlen[n] <= badlen[n] + 1;
                run[n] <= 0;
            end
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            if (done_ok) done_ok_cnt <= done_ok_cnt + 1;
        end
    end

    always @(posedge clk) if (!rst && req_valid && req_ready) hs_cnt <= hs_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents a request and returns #1 after the accepting edge (edge 0).
    task automatic send(input logic s, input logic [5:0] f, i, o, input logic hold);
        int k = 0;
        @(negedge clk);
        req_valid = 1'b1; req_sel = s; req_fdiv = f; req_idiv = i; req_odiv = o;
        while (!req_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // Counts edges after `start` until done is seen; edge_n = edge after which done appeared.
    task automatic wait_done(input int start, input int budget, output int edge_n, output logic ok_v);
        logic found = 1'b0;
        edge_n = start;
        ok_v   = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                ok_v  = done_ok;
                found = 1'b1;
                break;
            end
            @(posedge clk);
            edge_n++;
        end
        if (!found) begin
            check("done_timeout", 0, 1);
            edge_n = -1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e, p0, p1, b0, b1, r0, d0, dk, h0;
        logic ok;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pll_reset", pll_reset, 0);
        check("rst_fdiv", fdiv_o, 0);
        check("rst_idiv", idiv_o, 0);
        check("rst_odiv", odiv_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_ok", done_ok, 0);
        check("rst_lock_lost", lock_lost, 0);
        check("rst_req_ready", req_ready, 1);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_lock_lost", lock_lost, 0);

        // 1: ch1 reconfig, lock 40 cycles after release
        lock_delay[1] = 40;
        p1 = pulses[1]; b1 = badlen[1]; p0 = pulses[0]; d0 = done_cnt; dk = done_ok_cnt;
        send(1'b1, 6'd5, 6'd1, 6'd8, 1'b0);
        check("t1_busy", busy, 1);
        wait_done(0, 1000, e, ok);
        check("t1_done_ok", ok, 1);
        check("t1_fdiv1", fdiv_o[11:6], 5);
        check("t1_idiv1", idiv_o[11:6], 1);
        check("t1_odiv1", odiv_o[11:6], 8);
        repeat (2) @(negedge clk);
        check("t1_pulses", pulses[1] - p1, 1);
        check("t1_pulse_len", badlen[1] - b1, 0);
        check("t1_ch0_bus", {fdiv_o[5:0], idiv_o[5:0], odiv_o[5:0]}, 0);
        check("t1_ch0_reset", pulses[0] - p0, 0);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_done_ok_once", done_ok_cnt - dk, 1);
        check("t1_idle", busy, 0);

        // Minimum latency with lock held high throughout
        ign_rst[1] = 1'b1;
        send(1'b1, 6'd7, 6'd2, 6'd3, 1'b0);
        wait_done(0, 1000, e, ok);
        check("min_latency", e, 82);
        check("min_ok", ok, 1);

        // 3: one-cycle lock glitch when settle reaches 50
        send(1'b1, 6'd9, 6'd1, 6'd1, 1'b0);
        repeat (65) @(posedge clk);
        @(negedge clk);
        force_low[1] = 1'b1;
        @(posedge clk);
        #1 force_low[1] = 1'b0;
        wait_done(66, 1000, e, ok);
        check("glitch_latency", e, 133);
        check("glitch_ok", ok, 1);
        check("glitch_fdiv1", fdiv_o[11:6], 9);

        // 2: lock never rises -> 1 + 3 retries, then failure
        ign_rst[1] = 1'b0;
        lock_delay[1] = -1;
        repeat (2) @(negedge clk);
        p1 = pulses[1]; b1 = badlen[1];
        send(1'b1, 6'd2, 6'd3, 6'd4, 1'b0);
        wait_done(0, 3000, e, ok);
        check("tmo_latency", e, 872);
        check("tmo_done_ok", ok, 0);
        repeat (2) @(negedge clk);
        check("tmo_pulses", pulses[1] - p1, 4);
        check("tmo_pulse_len", badlen[1] - b1, 0);
        check("tmo_lock_lost", lock_lost, 0);
        lock_delay[1] = 3;
        repeat (10) @(negedge clk);

        // 4: request held during busy with a different sel
        h0 = hs_cnt; p1 = pulses[1];
        send(1'b0, 6'd11, 6'd2, 6'd5, 1'b1);
        req_sel = 1'b1; req_fdiv = 6'd13; req_idiv = 6'd4; req_odiv = 6'd6;
        wait_done(0, 1000, e, ok);
        check("hold_first_ok", ok, 1);
        check("hold_one_hs", hs_cnt - h0, 1);
        check("hold_fdiv0", fdiv_o[5:0], 11);
        check("hold_ch1_untouched", pulses[1] - p1, 0);
        e = 0;
        while (!req_ready && e < 10) begin
            @(negedge clk);
            e++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done(0, 1000, e, ok);
        check("hold_second_ok", ok, 1);
        check("hold_two_hs", hs_cnt - h0, 2);
        check("hold_fdiv1", fdiv_o[11:6], 13);
        check("hold_idiv1", idiv_o[11:6], 4);
        check("hold_odiv1", odiv_o[11:6], 6);
        check("hold_ch0_kept", {fdiv_o[5:0], idiv_o[5:0], odiv_o[5:0]}, {6'd11, 6'd2, 6'd5});

        // 5: lock loss on idle ch0, sticky, cleared by successful reconfig
        repeat (3) @(negedge clk);
        check("ll_before", lock_lost, 0);
        force_low[0] = 1'b1;
        repeat (3) @(negedge clk);
        force_low[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("ll_set", lock_lost, 2'b01);
        repeat (10) @(negedge clk);
        check("ll_sticky", lock_lost, 2'b01);
        send(1'b0, 6'd20, 6'd1, 6'd2, 1'b0);
        wait_done(0, 1000, e, ok);
        check("ll_reconfig_ok", ok, 1);
        check("ll_held_until_done", lock_lost, 2'b01);
        @(negedge clk);
        check("ll_cleared", lock_lost, 0);

        // 6: async reset during WAIT_LOCK
        lock_delay[1] = 150;
        send(1'b1, 6'd30, 6'd5, 6'd7, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("ar_busy", busy, 1);
        check("ar_fdiv1", fdiv_o[11:6], 30);
        #2 rst = 1'b1;
        #1;
        check("ar_pll_reset", pll_reset, 0);
        check("ar_fdiv", fdiv_o, 0);
        check("ar_idiv", idiv_o, 0);
        check("ar_odiv", odiv_o, 0);
        check("ar_busy_clr", busy, 0);
        check("ar_done", done, 0);
        check("ar_lock_lost", lock_lost, 0);
        check("ar_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("ar_ready_after", req_ready, 1);
        check("ar_idle_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
